// File: rtl/mem_arbiter.sv
// Shares one memory port between the fetch and load/store requesters, one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise data wins every tie.
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  // fetch requester
  input  logic                      i_if_req,
  input  logic [ADDR_WIDTH-1:0]     i_if_addr,
  output logic                      o_if_gnt,
  output logic                      o_if_rvalid,
  output logic                      o_if_err,
  output logic [DATA_WIDTH-1:0]     o_if_rdata,
  // load/store requester
  input  logic                      i_d_req,
  input  logic                      i_d_we,
  input  logic [ADDR_WIDTH-1:0]     i_d_addr,
  input  logic [DATA_WIDTH-1:0]     i_d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_d_wstrb,
  output logic                      o_d_gnt,
  output logic                      o_d_rvalid,
  output logic                      o_d_err,
  output logic [DATA_WIDTH-1:0]     o_d_rdata,
  // memory port
  output logic                      o_m_req,
  output logic                      o_m_we,
  output logic [ADDR_WIDTH-1:0]     o_m_addr,
  output logic [DATA_WIDTH-1:0]     o_m_wdata,
  output logic [DATA_WIDTH/8-1:0]   o_m_wstrb,
  input  logic                      i_m_gnt,
  input  logic                      i_m_rvalid,
  input  logic                      i_m_err,
  input  logic [DATA_WIDTH-1:0]     i_m_rdata,
  // status
  output logic                      o_busy,
  output logic [1:0]                o_dbg_state
);

  // Handshake: a requester holds req and its fields until its gnt is seen high
  // at a rising edge; gnt is only ever high together with i_m_gnt in IDLE, and
  // the matching rvalid (data or error) arrives in a later cycle for one cycle.

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] cnt_q, cnt_d;

  logic win_data;
  logic any_req;

  logic                  m_req, m_we;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_W-1:0]     m_wstrb;
  logic                  gnt_fire;
  logic                  rsp_valid, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  always_comb begin
    if (i_if_req && i_d_req) win_data = (last_owner_q == OWN_FETCH);
    else                     win_data = i_d_req;
  end
`else
  always_comb begin
    win_data = i_d_req;
  end
`endif

  assign any_req = i_if_req | i_d_req;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    gnt_fire  = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
`ifdef MEM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          m_req = 1'b1;
          if (win_data) begin
            m_we    = i_d_we;
            m_addr  = i_d_addr;
            m_wdata = i_d_wdata;
            m_wstrb = i_d_wstrb;
          end else begin
            m_addr  = i_if_addr;
          end
          if (i_m_gnt) begin
            gnt_fire = 1'b1;
            owner_d  = win_data ? OWN_DATA : OWN_FETCH;
            cnt_d    = '0;
            state_d  = ST_WAIT;
`ifdef MEM_ARB_RR_EN
            last_owner_d = win_data ? OWN_DATA : OWN_FETCH;
`endif
          end
        end
      end
      ST_WAIT: begin
        // A response arriving in the timeout cycle still completes normally.
        if (i_m_rvalid) begin
          rsp_valid = 1'b1;
          rsp_err   = i_m_err;
          rsp_data  = i_m_rdata;
          state_d   = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid = 1'b1;
          rsp_err   = 1'b1;
          cnt_d     = '0;
          state_d   = ST_DRAIN;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DRAIN: begin
        // Swallow the late response of the timed-out transaction, or give up on it.
        if (i_m_rvalid || (cnt_q == CNT_LAST)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are forced low while reset is held, independent of the inputs.
  always_comb begin
    o_m_req     = 1'b0;
    o_m_we      = 1'b0;
    o_m_addr    = '0;
    o_m_wdata   = '0;
    o_m_wstrb   = '0;
    o_if_gnt    = 1'b0;
    o_d_gnt     = 1'b0;
    o_if_rvalid = 1'b0;
    o_if_err    = 1'b0;
    o_if_rdata  = '0;
    o_d_rvalid  = 1'b0;
    o_d_err     = 1'b0;
    o_d_rdata   = '0;
    o_busy      = 1'b0;
    o_dbg_state = 2'd0;
    if (i_rst) begin
      o_m_req     = m_req;
      o_m_we      = m_we;
      o_m_addr    = m_addr;
      o_m_wdata   = m_wdata;
      o_m_wstrb   = m_wstrb;
      o_if_gnt    = gnt_fire & ~win_data;
      o_d_gnt     = gnt_fire & win_data;
      o_busy      = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
      o_dbg_state = state_q;
      if (owner_q == OWN_DATA) begin
        o_d_rvalid = rsp_valid;
        o_d_err    = rsp_err;
        o_d_rdata  = rsp_data;
      end else begin
        o_if_rvalid = rsp_valid;
        o_if_err    = rsp_err;
        o_if_rdata  = rsp_data;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DATA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) last_owner_q <= OWN_DATA;
    else        last_owner_q <= last_owner_d;
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all outputs compared every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic i_rst = 1'b0;

  logic          i_if_req, i_d_req, i_d_we, i_m_gnt, i_m_rvalid, i_m_err;
  logic [AW-1:0] i_if_addr, i_d_addr;
  logic [DW-1:0] i_d_wdata, i_m_rdata;
  logic [SW-1:0] i_d_wstrb;
  logic          o_if_gnt, o_if_rvalid, o_if_err, o_d_gnt, o_d_rvalid, o_d_err;
  logic          o_m_req, o_m_we, o_busy;
  logic [DW-1:0] o_if_rdata, o_d_rdata, o_m_wdata;
  logic [AW-1:0] o_m_addr;
  logic [SW-1:0] o_m_wstrb;
  logic [1:0]    o_dbg_state;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid), .o_if_err(o_if_err), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata), .i_d_wstrb(i_d_wstrb),
    .o_d_gnt(o_d_gnt), .o_d_rvalid(o_d_rvalid), .o_d_err(o_d_err), .o_d_rdata(o_d_rdata),
    .o_m_req(o_m_req), .o_m_we(o_m_we), .o_m_addr(o_m_addr), .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb),
    .i_m_gnt(i_m_gnt), .i_m_rvalid(i_m_rvalid), .i_m_err(i_m_err), .i_m_rdata(i_m_rdata),
    .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 = free, 1 = transaction outstanding, 2 = discarding after timeout.
  // age counts cycles since the grant (mode 1) or since drain entry (mode 2).
  int   mode   = 0;
  logic m_own  = 1'b1;
  int   age    = 0;
  logic last_d = 1'b1;
  logic if_gnt_seen = 1'b0;
  logic d_gnt_seen  = 1'b0;

  logic          e_ifg, e_dg, e_ifrv, e_iferr, e_drv, e_derr, e_mreq, e_mwe, e_busy;
  logic [DW-1:0] e_ifrd, e_drd, e_mwd;
  logic [AW-1:0] e_maddr;
  logic [SW-1:0] e_mws;
  logic          wd, rv, er;
  logic [DW-1:0] rd;

  always @(negedge clk) begin : compare
    {e_ifg, e_dg, e_ifrv, e_iferr, e_drv, e_derr, e_mreq, e_mwe, e_busy} = '0;
    e_ifrd = '0; e_drd = '0; e_mwd = '0; e_maddr = '0; e_mws = '0;
    rv = 1'b0; er = 1'b0; rd = '0;
    if (!i_rst) begin
      mode   = 0;
      last_d = 1'b1;
    end else if (mode == 0) begin
      if (i_if_req || i_d_req) begin
`ifdef MEM_ARB_RR_EN
        wd = (i_if_req && i_d_req) ? !last_d : i_d_req;
`else
        wd = i_d_req;
`endif
        e_mreq  = 1'b1;
        e_maddr = wd ? i_d_addr : i_if_addr;
        e_mwe   = wd ? i_d_we : 1'b0;
        e_mwd   = wd ? i_d_wdata : '0;
        e_mws   = wd ? i_d_wstrb : '0;
        if (i_m_gnt) begin
          e_dg   = wd;
          e_ifg  = !wd;
          mode   = 1;
          m_own  = wd;
          age    = 1;
          last_d = wd;
        end
      end
    end else if (mode == 1) begin
      e_busy = 1'b1;
      if (i_m_rvalid) begin
        rv = 1'b1; er = i_m_err; rd = i_m_rdata;
        mode = 0;
      end else if (age == TO) begin
        rv = 1'b1; er = 1'b1;
        mode = 2;
        age  = 0;
      end else begin
        age++;
      end
    end else begin
      e_busy = 1'b1;
      if (i_m_rvalid || age == TO - 1) mode = 0;
      else age++;
    end
    if (m_own) begin
      e_drv = rv; e_derr = er; e_drd = rd;
    end else begin
      e_ifrv = rv; e_iferr = er; e_ifrd = rd;
    end

    chk1("if_gnt", o_if_gnt, e_ifg);
    chk1("d_gnt", o_d_gnt, e_dg);
    chk1("if_rvalid", o_if_rvalid, e_ifrv);
    chk1("if_err", o_if_err, e_iferr);
    chk32("if_rdata", o_if_rdata, e_ifrd);
    chk1("d_rvalid", o_d_rvalid, e_drv);
    chk1("d_err", o_d_err, e_derr);
    chk32("d_rdata", o_d_rdata, e_drd);
    chk1("m_req", o_m_req, e_mreq);
    chk1("m_we", o_m_we, e_mwe);
    chk32("m_addr", o_m_addr, e_maddr);
    chk32("m_wdata", o_m_wdata, e_mwd);
    chk32("m_wstrb", 32'(o_m_wstrb), 32'(e_mws));
    chk1("busy", o_busy, e_busy);

    if_gnt_seen = o_if_gnt;
    d_gnt_seen  = o_d_gnt;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_if_req = 1'b0; i_if_addr = '0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = '0; i_d_wdata = '0; i_d_wstrb = '0;
    i_m_gnt = 1'b0; i_m_rvalid = 1'b0; i_m_err = 1'b0; i_m_rdata = '0;
  endtask

  task automatic do_reset();
    step();
    i_rst = 1'b0;
    idle_in();
    step();
    step();
    i_rst = 1'b1;
  endtask

  logic first_d;

  initial begin
    idle_in();
    #2;
    chk1("reset_m_req", o_m_req, 1'b0);
    chk1("reset_busy", o_busy, 1'b0);
    do_reset();

    // Single fetch, response two cycles after the grant.
    step(); i_if_req = 1'b1; i_if_addr = 32'h100; i_m_gnt = 1'b1; #2;
    chk1("t1_if_gnt", o_if_gnt, 1'b1);
    chk1("t1_d_gnt", o_d_gnt, 1'b0);
    chk32("t1_m_addr", o_m_addr, 32'h100);
    step(); i_if_req = 1'b0; i_m_gnt = 1'b0; #2;
    chk1("t1_busy_c1", o_busy, 1'b1);
    chk1("t1_rvalid_c1", o_if_rvalid, 1'b0);
    step(); i_m_rvalid = 1'b1; i_m_rdata = 32'h13; #2;
    chk1("t1_if_rvalid", o_if_rvalid, 1'b1);
    chk32("t1_if_rdata", o_if_rdata, 32'h13);
    chk1("t1_busy_c2", o_busy, 1'b1);
    chk32("t1_d_side", {29'd0, o_d_gnt, o_d_rvalid, o_d_err}, 32'd0);
    chk32("t1_d_rdata", o_d_rdata, 32'd0);
    step(); idle_in(); #2;
    chk1("t1_busy_c3", o_busy, 1'b0);

    // Simultaneous requests, twice.
    do_reset();
`ifdef MEM_ARB_RR_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    for (int rep = 0; rep < 2; rep++) begin
      step();
      i_if_req = 1'b1; i_if_addr = 32'h0;
      i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h200; i_d_wdata = 32'hA5A5_0001; i_d_wstrb = 4'hF;
      i_m_gnt = 1'b1; #2;
      chk1("t2_first_dgnt", o_d_gnt, first_d);
      chk1("t2_first_ifgnt", o_if_gnt, !first_d);
      chk32("t2_first_addr", o_m_addr, first_d ? 32'h200 : 32'h0);
      step();
      if (first_d) i_d_req = 1'b0; else i_if_req = 1'b0;
      i_m_rvalid = 1'b1; i_m_rdata = 32'h11; #2;
      chk32("t2_pend_gnt", {30'd0, o_if_gnt, o_d_gnt}, 32'd0);
      chk1("t2_first_rv", first_d ? o_d_rvalid : o_if_rvalid, 1'b1);
      step(); i_m_rvalid = 1'b0; #2;
      chk1("t2_second_gnt", first_d ? o_if_gnt : o_d_gnt, 1'b1);
      step();
      i_if_req = 1'b0; i_d_req = 1'b0; i_m_gnt = 1'b0; i_m_rvalid = 1'b1; #2;
      chk1("t2_second_rv", first_d ? o_if_rvalid : o_d_rvalid, 1'b1);
      step(); idle_in();
    end

    // Stalled memory grant.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(); i_d_req = 1'b1; i_d_addr = 32'h300; i_m_gnt = 1'b0; #2;
      chk1("t3_m_req", o_m_req, 1'b1);
      chk32("t3_m_addr", o_m_addr, 32'h300);
      chk1("t3_no_gnt", o_d_gnt, 1'b0);
    end
    step(); i_m_gnt = 1'b1; #2;
    chk1("t3_gnt", o_d_gnt, 1'b1);
    step(); i_d_req = 1'b0; i_m_gnt = 1'b0; i_m_rvalid = 1'b1; #2;
    chk1("t3_rvalid", o_d_rvalid, 1'b1);
    step(); idle_in();

    // Timeout, then a late response swallowed in drain.
    do_reset();
    step(); i_d_req = 1'b1; i_d_addr = 32'h400; i_m_gnt = 1'b1; #2;
    chk1("t4_gnt", o_d_gnt, 1'b1);
    for (int k = 1; k < TO; k++) begin
      step(); i_d_req = 1'b0; i_m_gnt = 1'b0; i_m_rdata = 32'hFFFF; #2;
      chk1("t4_early_rv", o_d_rvalid, 1'b0);
    end
    step(); #2;
    chk1("t4_to_rvalid", o_d_rvalid, 1'b1);
    chk1("t4_to_err", o_d_err, 1'b1);
    chk32("t4_to_rdata", o_d_rdata, 32'd0);
    step(); i_if_req = 1'b1; i_if_addr = 32'h500; i_m_gnt = 1'b1; i_m_rvalid = 1'b1; i_m_rdata = 32'h77; #2;
    chk32("t4_drain_quiet", {28'd0, o_if_rvalid, o_d_rvalid, o_if_gnt, o_m_req}, 32'd0);
    step(); i_m_rvalid = 1'b0; #2;
    chk1("t4_next_gnt", o_if_gnt, 1'b1);
    step(); i_if_req = 1'b0; i_m_gnt = 1'b0; i_m_rvalid = 1'b1; #2;
    chk1("t4_next_rv", o_if_rvalid, 1'b1);
    step(); idle_in();

    // Error pass-through, then async reset mid-WAIT.
    do_reset();
    step(); i_if_req = 1'b1; i_if_addr = 32'h600; i_m_gnt = 1'b1; #2;
    chk1("t5_gnt", o_if_gnt, 1'b1);
    step(); i_if_req = 1'b0; i_m_gnt = 1'b0; i_m_rvalid = 1'b1; i_m_err = 1'b1; i_m_rdata = 32'hDEAD; #2;
    chk1("t5_rvalid", o_if_rvalid, 1'b1);
    chk1("t5_err", o_if_err, 1'b1);
    chk32("t5_rdata", o_if_rdata, 32'hDEAD);
    step(); idle_in(); i_if_req = 1'b1; i_if_addr = 32'h700; i_m_gnt = 1'b1; #2;
    chk1("t5_gnt2", o_if_gnt, 1'b1);
    step(); i_if_req = 1'b0; i_m_gnt = 1'b0; i_d_req = 1'b1; i_d_addr = 32'h900; #1;
    i_rst = 1'b0; #1;
    chk32("t5_clr_ctl", {23'd0, o_if_gnt, o_if_rvalid, o_if_err, o_d_gnt, o_d_rvalid, o_d_err,
                         o_m_req, o_m_we, o_busy}, 32'd0);
    chk1("t5_clr_bus", |{o_m_addr, o_m_wdata, o_m_wstrb, o_if_rdata, o_d_rdata}, 1'b0);
    step(); i_m_rvalid = 1'b1; i_m_rdata = 32'h55; #2;
    chk32("t5_held", {29'd0, o_m_req, o_busy, o_if_rvalid}, 32'd0);
    step(); i_rst = 1'b1; i_d_req = 1'b0; #2;
    chk32("t5_stale_rv", {29'd0, o_if_rvalid, o_d_rvalid, o_busy}, 32'd0);
    step(); i_m_rvalid = 1'b0; i_if_req = 1'b1; i_if_addr = 32'h800; i_m_gnt = 1'b1; #2;
    chk1("t5_regnt", o_if_gnt, 1'b1);
    step(); i_if_req = 1'b0; i_m_gnt = 1'b0; i_m_rvalid = 1'b1; i_m_err = 1'b0; i_m_rdata = 32'h42; #2;
    chk32("t5_rerdata", o_if_rdata, 32'h42);
    step(); idle_in();

    // Random traffic; requesters obey hold-until-grant, memory behaves arbitrarily.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (!(i_if_req && !if_gnt_seen)) begin
        i_if_req  = ($urandom_range(0, 99) < 45);
        i_if_addr = $urandom;
      end
      if (!(i_d_req && !d_gnt_seen)) begin
        i_d_req   = ($urandom_range(0, 99) < 45);
        i_d_we    = $urandom_range(0, 1) == 1;
        i_d_addr  = $urandom;
        i_d_wdata = $urandom;
        i_d_wstrb = 4'($urandom_range(0, 15));
      end
      i_m_gnt    = ($urandom_range(0, 99) < 60);
      i_m_rvalid = ($urandom_range(0, 99) < 30);
      i_m_err    = ($urandom_range(0, 99) < 20);
      i_m_rdata  = $urandom;
      i_rst      = ($urandom_range(0, 299) != 0);
    end
    step();
    i_rst = 1'b1;
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single unified memory port between the instruction-fetch requester and the load/store requester of the processor core. Allows one outstanding transaction at a time. Routes each response back to the requester that owns it. Converts a missing memory response into an error completion after a programmable timeout. Sits between the IFU/LSU and the memory, replacing the separate IMEM/DMEM paths once the core moves to a shared memory.

## Interface
- `ADDR_WIDTH`, 32: width of every address bus.
- `DATA_WIDTH`, 32: data bus width (XLEN); `wstrb` width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255: number of WAIT cycles before a timeout; legal range 1..65535.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: asynchronous, active-low reset.
- `i_if_req` in 1: fetch request; held with `i_if_addr` until `o_if_gnt`.
- `i_if_addr` in ADDR_WIDTH: fetch address.
- `o_if_gnt` / `o_if_rvalid` / `o_if_err` out 1: fetch grant, response valid, and error (err is valid only with rvalid).
- `o_if_rdata` out DATA_WIDTH: fetch read data.
- `i_d_req`, `i_d_we` in 1: data request and write enable; held with address/wdata/wstrb until `o_d_gnt`.
- `i_d_addr` in ADDR_WIDTH, `i_d_wdata` in DATA_WIDTH, `i_d_wstrb` in DATA_WIDTH/8: data request fields.
- `o_d_gnt` / `o_d_rvalid` / `o_d_err` out 1; `o_d_rdata` out DATA_WIDTH: data grant and response (writes also receive rvalid).
- `o_m_req`, `o_m_we` out 1; `o_m_addr`, `o_m_wdata`, `o_m_wstrb` out: request to memory.
- `i_m_gnt`, `i_m_rvalid`, `i_m_err` in 1; `i_m_rdata` in DATA_WIDTH: memory grant and response.
- `o_busy` out 1: high in WAIT or DRAIN.

## Operation
State machine:
- **IDLE**
  - Selects a winner among the asserted `i_if_req` / `i_d_req` (combinationally).
  - Drives `o_m_*` from the winner's fields, with `o_m_req=1`.
  - If `i_m_gnt=1`, pulses the winner's gnt in the same cycle, latches `owner`, clears the timeout counter, and moves to WAIT.
  - If there is no request, `o_m_req=0`; the `o_m_*` fields are 0.
- **WAIT**
  - Holds `o_m_req=0`; the counter increments each cycle.
  - When `i_m_rvalid=1`: drives `owner`'s rvalid, rdata = `i_m_rdata`, and err = `i_m_err` (combinational pass-through), then moves to IDLE.
  - Otherwise, when the counter reaches `TIMEOUT_CYCLES-1`: pulses `owner`'s rvalid with err=1 and rdata=0, clears the counter, and moves to DRAIN.
- **DRAIN**
  - No grants are issued.
  - Discards a stale `i_m_rvalid` and moves to IDLE.
  - If `TIMEOUT_CYCLES` further cycles pass with no response, moves to IDLE anyway.

Arbitration rules:
- A request that is not granted stays pending. gnt is never asserted without `i_m_gnt`.
- Default priority: data beats fetch on a tie.

Rules for every state and edge case:
- Non-owner rvalid/err/rdata are always 0. A requester's rdata is 0 whenever its rvalid is 0.
- `i_m_rvalid` in IDLE is ignored.
- `i_m_rvalid` and timeout in the same cycle: the response wins and completes normally.
- The counter saturates and never wraps.

## Timing
- Reset (async assert): state=IDLE, counter=0, `last_owner`=DATA; every output is 0 immediately and stays 0 while reset is held.
- Reset mid-transaction abandons the transaction. No rvalid is produced for it.
- Grant latency is 0 cycles from `i_m_gnt` when in IDLE.
- Response latency is 0 cycles from `i_m_rvalid` to the requester.
- The cycle after a response is always IDLE, so at most 1 transaction per 2 cycles.
- A timeout error appears exactly `TIMEOUT_CYCLES` cycles after the grant cycle.
- The DRAIN exit without a response occurs `TIMEOUT_CYCLES` cycles after DRAIN entry.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On a tie, the port not equal to `last_owner` wins. `last_owner` updates on every grant and resets to DATA, so fetch wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority. Data always wins a tie; `last_owner` is not implemented.

## Test plan
- **Single fetch.** Fetch of 0x100, `i_m_gnt` in the same cycle, `i_m_rvalid` 2 cycles later with rdata 0x00000013.
  - `o_if_gnt` pulses in cycle 0.
  - `o_if_rvalid` and rdata 0x13 appear in cycle 2.
  - `o_busy` is high in cycles 1–2; d-side outputs stay 0.
- **Simultaneous requests, repeated.** Fetch 0x0 and store 0x200 (wstrb 0xF) both requested; memory grants immediately and responds after 1 cycle.
  - With RR: fetch is granted first, then data.
  - Without RR: data is granted first, then fetch.
  - The pending requester's gnt stays 0 until its turn.
- **Stalled grant.** Hold `i_m_gnt=0` for 3 cycles with `i_d_req=1`.
  - `o_m_req=1` and `o_m_addr` are stable all 3 cycles.
  - `o_d_gnt` pulses only in the cycle `i_m_gnt`=1.
- **Timeout.** `TIMEOUT_CYCLES`=4, load granted, no response.
  - `o_d_rvalid=1`, `o_d_err=1`, rdata 0 appear exactly 4 cycles after the grant.
  - A late `i_m_rvalid` in DRAIN produces no output, and the next fetch is granted only after it.
- **Error pass-through and async reset.**
  - A response with `i_m_err=1` gives `o_if_err=1` alongside rvalid.
  - Asserting `i_rst` low mid-WAIT clears all outputs asynchronously.
  - After release, the first response is ignored and a new request is granted from IDLE.
